// File: rtl/data_mem_ctrl_if.sv
// Core request/response and word-bus memory signals of the data memory controller.
// slave: controller view; master: core + memory view.
interface data_mem_ctrl_if;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  load;
   logic [1:0]  store;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, load, store, addr, wdata, mem_ack, mem_rdata,
      output req_ready, rsp_valid, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output req_valid, req_write, load, store, addr, wdata, mem_ack, mem_rdata,
      input  req_ready, rsp_valid, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: sizes and aligns core loads/stores onto a 32-bit word bus.
// Macro MISALIGNED_SPLIT_EN: misaligned accesses become two word accesses instead of err.
module data_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input logic            clk,
   input logic            rst,
   data_mem_ctrl_if.slave bus
);
   // state | meaning
   // IDLE  | ready for a request
   // ACC0  | first (or only) word access; rejected misaligned access passes through
   // ACC1  | spill word access at next word address (split build only)
   // RESP  | one-cycle response
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
`ifdef MISALIGNED_SPLIT_EN
      ACC1 = 2'd2,
`endif
      RESP = 2'd3
   } state_t;

   localparam logic [1:0]  SZ_B     = 2'd0;
   localparam logic [1:0]  SZ_H     = 2'd1;
   localparam logic [1:0]  SZ_W     = 2'd2;
   localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rd0_q, rdata_q;
   logic        write_q, sign_q, err_q;
   logic [1:0]  size_q;
   logic [15:0] tmr_q;

   logic        accept, ack, fail, in_acc1, misal, mem_go;
   logic [3:0]  mask;
   logic [7:0]  be8;
   logic [63:0] wd64, rd64;
   logic [31:0] rd_sh, rd_ext;

`ifdef MISALIGNED_SPLIT_EN
   assign in_acc1 = (state_q == ACC1);
`else
   assign in_acc1 = 1'b0;
`endif

   // Lanes shifted past bit 3 belong to the spill word.
   always_comb begin
      case (size_q)
         SZ_B:    mask = 4'b0001;
         SZ_H:    mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
      be8   = {4'b0000, mask} << addr_q[1:0];
      misal = |be8[7:4];
      wd64  = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
      rd64  = in_acc1 ? {bus.mem_rdata, rd0_q} : {32'h0, bus.mem_rdata};
      rd_sh = 32'(rd64 >> {addr_q[1:0], 3'b000});
      case (size_q)
         SZ_B:    rd_ext = {{24{sign_q & rd_sh[7]}}, rd_sh[7:0]};
         SZ_H:    rd_ext = {{16{sign_q & rd_sh[15]}}, rd_sh[15:0]};
         default: rd_ext = rd_sh;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      ack     = 1'b0;
      fail    = 1'b0;
      mem_go  = 1'b0;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            accept  = 1'b1;
            state_d = ACC0;
         end
         ACC0: begin
`ifdef MISALIGNED_SPLIT_EN
            mem_go = 1'b1;
            if (bus.mem_ack) begin
               ack     = 1'b1;
               state_d = misal ? ACC1 : RESP;
            end else if (tmr_q == 16'd0) begin
               fail    = 1'b1;
               state_d = RESP;
            end
`else
            if (misal) begin
               fail    = 1'b1;
               state_d = RESP;
            end else begin
               mem_go = 1'b1;
               if (bus.mem_ack) begin
                  ack     = 1'b1;
                  state_d = RESP;
               end else if (tmr_q == 16'd0) begin
                  fail    = 1'b1;
                  state_d = RESP;
               end
            end
`endif
         end
`ifdef MISALIGNED_SPLIT_EN
         ACC1: begin
            mem_go = 1'b1;
            if (bus.mem_ack) begin
               ack     = 1'b1;
               state_d = RESP;
            end else if (tmr_q == 16'd0) begin
               fail    = 1'b1;
               state_d = RESP;
            end
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      bus.req_ready = (state_q == IDLE);
      bus.rsp_valid = (state_q == RESP);
      bus.err       = (state_q == RESP) & err_q;
      bus.rdata     = (state_q == RESP) ? rdata_q : 32'h0;
      bus.mem_req   = mem_go;
      bus.mem_we    = mem_go & write_q;
      bus.mem_addr  = 32'h0;
      bus.mem_be    = 4'b0000;
      bus.mem_wdata = 32'h0;
      if (mem_go) begin
         bus.mem_addr = {addr_q[31:2] + (in_acc1 ? 30'd1 : 30'd0), 2'b00};
         bus.mem_be   = in_acc1 ? be8[7:4] : be8[3:0];
         if (write_q) bus.mem_wdata = in_acc1 ? wd64[63:32] : wd64[31:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rd0_q   <= 32'h0;
         rdata_q <= 32'h0;
         write_q <= 1'b0;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= SZ_W;
         tmr_q   <= 16'd0;
      end else if (accept) begin
         addr_q  <= bus.addr;
         write_q <= bus.req_write;
         wdata_q <= bus.wdata;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
         tmr_q   <= TMR_LOAD;
         sign_q  <= 1'b0;
         size_q  <= SZ_W;
         if (bus.req_write) begin
            case (bus.store)
               2'b01:   size_q <= SZ_H;
               2'b10:   size_q <= SZ_B;
               default: size_q <= SZ_W;
            endcase
         end else begin
            case (bus.load)
               3'b001:  begin size_q <= SZ_H; sign_q <= 1'b1; end
               3'b010:  begin size_q <= SZ_B; sign_q <= 1'b1; end
               3'b011:  size_q <= SZ_H;
               3'b100:  size_q <= SZ_B;
               default: size_q <= SZ_W;
            endcase
         end
      end else if (ack) begin
         tmr_q <= TMR_LOAD;
         if (!write_q) begin
            rd0_q   <= bus.mem_rdata;
            rdata_q <= rd_ext;
         end
      end else if (fail) begin
         err_q   <= 1'b1;
         rdata_q <= 32'h0;
         tmr_q   <= 16'd0;
      end else if (mem_go) begin
         tmr_q <= tmr_q - 16'd1;
      end else if (state_q == RESP) begin
         tmr_q <= 16'd0;
      end
   end
endmodule
